// File: rtl/icache_refill_write_if.sv
// Refill-path bus: ctrl request, memory read channel and array write ports.
// The master modport is the refill block; the slave modport is its environment.
interface icache_refill_write_if #(
  parameter int TAG_W = 20
);
  logic               ctrl2refill_valid;
  logic [5:0]         ctrl2refill_index;
  logic [2:0]         ctrl2refill_way;
  logic [TAG_W-1:0]   ctrl2refill_tag;
  logic               refill2ctrl_ready;
  logic               refill2ctrl_done;
  logic               refill2ctrl_error;

  logic               refill2mem_req_valid;
  logic [TAG_W+11:0]  refill2mem_addr;
  logic               mem2refill_req_ready;
  logic               mem2refill_valid;
  logic [63:0]        mem2refill_rdata;
  logic               mem2refill_last;
  logic               refill2mem_ready;

  logic               refill2data_array_valid;
  logic [5:0]         refill2data_array_index;
  logic [2:0]         refill2data_array_way;
  logic [1:0]         refill2data_array_offset;
  logic [127:0]       refill2data_array_wdata;

  logic               refill2tag_array_valid;
  logic [5:0]         refill2tag_array_index;
  logic [2:0]         refill2tag_array_way;
  logic [TAG_W-1:0]   refill2tag_array_tag;

  logic               refill2plru_valid;
  logic [5:0]         refill2plru_index;
  logic [2:0]         refill2plru_way;

  modport master (
    input  ctrl2refill_valid, ctrl2refill_index, ctrl2refill_way, ctrl2refill_tag,
    output refill2ctrl_ready, refill2ctrl_done, refill2ctrl_error,
    output refill2mem_req_valid, refill2mem_addr,
    input  mem2refill_req_ready, mem2refill_valid, mem2refill_rdata, mem2refill_last,
    output refill2mem_ready,
    output refill2data_array_valid, refill2data_array_index, refill2data_array_way,
    output refill2data_array_offset, refill2data_array_wdata,
    output refill2tag_array_valid, refill2tag_array_index, refill2tag_array_way,
    output refill2tag_array_tag,
    output refill2plru_valid, refill2plru_index, refill2plru_way
  );

  modport slave (
    output ctrl2refill_valid, ctrl2refill_index, ctrl2refill_way, ctrl2refill_tag,
    input  refill2ctrl_ready, refill2ctrl_done, refill2ctrl_error,
    input  refill2mem_req_valid, refill2mem_addr,
    output mem2refill_req_ready, mem2refill_valid, mem2refill_rdata, mem2refill_last,
    input  refill2mem_ready,
    input  refill2data_array_valid, refill2data_array_index, refill2data_array_way,
    input  refill2data_array_offset, refill2data_array_wdata,
    input  refill2tag_array_valid, refill2tag_array_index, refill2tag_array_way,
    input  refill2tag_array_tag,
    input  refill2plru_valid, refill2plru_index, refill2plru_way
  );
endinterface

// File: rtl/icache_refill_write.sv
// I-cache line refill: requests a 64-byte line, packs 64-bit beats into 128-bit
// data-array writes, then writes the tag and plru entry to validate the line.
module icache_refill_write #(
  parameter int TAG_W = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  icache_refill_write_if.master bus,
  output logic [2:0]           dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid/req_valid never depend on the matching ready.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RECV = 3'd2,
    S_TAG  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q;
  logic [63:0]        low_q;
  logic [5:0]         index_q;
  logic [2:0]         way_q;
  logic [TAG_W-1:0]   tag_q;
  logic               err_q;

  logic beat_acc;
  logic last_beat;
  logic malformed;

  assign beat_acc  = (state_q == S_RECV) && bus.mem2refill_valid;
  assign last_beat = (cnt_q == 3'd7);
  // A burst is malformed when the last marker and the eighth beat disagree.
  assign malformed = beat_acc && (bus.mem2refill_last != last_beat);
  assign dbg_state = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      low_q   <= 64'd0;
      index_q <= 6'd0;
      way_q   <= 3'd0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && bus.ctrl2refill_valid) begin
        index_q <= bus.ctrl2refill_index;
        way_q   <= bus.ctrl2refill_way;
        tag_q   <= bus.ctrl2refill_tag;
        err_q   <= 1'b0;
      end
      if ((state_q == S_REQ) && bus.mem2refill_req_ready) begin
        cnt_q <= 3'd0;
      end
      if (beat_acc) begin
        cnt_q <= cnt_q + 3'd1;
        if (!cnt_q[0]) begin
          low_q <= bus.mem2refill_rdata;
        end
      end
      if (malformed) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.ctrl2refill_valid)    state_d = S_REQ;
      S_REQ:  if (bus.mem2refill_req_ready) state_d = S_RECV;
      S_RECV: begin
        // Errors reuse DONE so the error pulse has the same one-cycle shape as done.
        if (beat_acc && (bus.mem2refill_last || last_beat)) begin
          state_d = (bus.mem2refill_last && last_beat) ? S_TAG : S_DONE;
        end
      end
      S_TAG:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.refill2ctrl_ready        = (state_q == S_IDLE);
    bus.refill2ctrl_done         = (state_q == S_DONE) && !err_q;
    bus.refill2ctrl_error        = (state_q == S_DONE) && err_q;
    bus.refill2mem_req_valid     = (state_q == S_REQ);
    bus.refill2mem_addr          = {tag_q, index_q, 6'b0};
    bus.refill2mem_ready         = (state_q == S_RECV);

    bus.refill2data_array_valid  = beat_acc && cnt_q[0];
    bus.refill2data_array_index  = 6'd0;
    bus.refill2data_array_way    = 3'd0;
    bus.refill2data_array_offset = 2'd0;
    bus.refill2data_array_wdata  = 128'd0;
    if (beat_acc && cnt_q[0]) begin
      bus.refill2data_array_index  = index_q;
      bus.refill2data_array_way    = way_q;
      bus.refill2data_array_offset = cnt_q[2:1];
      bus.refill2data_array_wdata  = {bus.mem2refill_rdata, low_q};
    end

    bus.refill2tag_array_valid   = (state_q == S_TAG);
    bus.refill2tag_array_index   = index_q;
    bus.refill2tag_array_way     = way_q;
    bus.refill2tag_array_tag     = tag_q;
    bus.refill2plru_valid        = (state_q == S_TAG);
    bus.refill2plru_index        = index_q;
    bus.refill2plru_way          = way_q;
  end
endmodule
